// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates one active-low row at a time and samples the columns.
// Whole-frame results are debounced into a key code, a press strobe and a held level.
//
// state      | meaning
// -----------+----------------------------------------------------
// S_IDLE     | no key accepted, waiting for a single-key frame
// S_DEBOUNCE | counting consecutive frames showing the same key
// S_PRESSED  | key accepted, counting consecutive empty frames
module keypad_scan #(
  parameter int SCAN_CNT        = 50_000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic [3:0] col_in,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int CW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_CNT - 1);
  localparam logic [DW-1:0] DF_LAST  = DW'(DEBOUNCE_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED} state_t;

  logic [3:0]    r_sync1, r_col_s;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_row;
  logic          r_acc_any, r_acc_multi;
  logic [3:0]    r_acc_code;
  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_dcnt, w_dcnt_nxt, r_rcnt, w_rcnt_nxt;
  logic [3:0]    r_cand, w_cand_nxt;
  logic [3:0]    r_key_code;
  logic          r_key_valid, r_key_down;

  logic          w_wrap, w_frame_end;
  logic [1:0]    w_row_idx, w_col_idx;
  logic [3:0]    w_hit;
  logic [2:0]    w_hit_cnt;
  logic          w_m_any, w_m_multi;
  logic [3:0]    w_m_code;
  logic          w_f_none, w_f_single;
  logic          w_accept, w_release;

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_sync1 <= 4'hF;
      r_col_s <= 4'hF;
    end else begin
      r_sync1 <= col_in;
      r_col_s <= r_sync1;
    end
  end

  assign w_wrap = (r_cnt == CNT_LAST);

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_cnt <= '0;
      r_row <= 4'b1110;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_row <= {r_row[2:0], r_row[3]};
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_row_idx = 2'd0;
    case (r_row)
      4'b1101: w_row_idx = 2'd1;
      4'b1011: w_row_idx = 2'd2;
      4'b0111: w_row_idx = 2'd3;
      default: w_row_idx = 2'd0;
    endcase
  end

  assign w_hit     = ~r_col_s;
  assign w_hit_cnt = {2'b00, w_hit[0]} + {2'b00, w_hit[1]} + {2'b00, w_hit[2]} + {2'b00, w_hit[3]};

  always_comb begin
    w_col_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_hit[i]) w_col_idx = 2'(i);
    end
  end

  // Merge the current row sample into the running frame result; a hit in a second row is MULTI.
  assign w_m_any   = r_acc_any | (w_hit_cnt != 3'd0);
  assign w_m_multi = r_acc_multi | (w_hit_cnt > 3'd1) | (r_acc_any & (w_hit_cnt != 3'd0));
  assign w_m_code  = (!r_acc_any && (w_hit_cnt == 3'd1)) ? {w_row_idx, w_col_idx} : r_acc_code;

  assign w_frame_end = w_wrap & (w_row_idx == 2'd3);
  assign w_f_none    = ~w_m_any;
  assign w_f_single  = w_m_any & ~w_m_multi;

  always_ff @(posedge sclk) begin
    if (s_rst || w_frame_end) begin
      r_acc_any   <= 1'b0;
      r_acc_multi <= 1'b0;
      r_acc_code  <= 4'd0;
    end else if (w_wrap) begin
      r_acc_any   <= w_m_any;
      r_acc_multi <= w_m_multi;
      r_acc_code  <= w_m_code;
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_state <= S_IDLE;
      r_dcnt  <= '0;
      r_rcnt  <= '0;
      r_cand  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_rcnt_nxt  = r_rcnt;
    w_cand_nxt  = r_cand;
    if (w_frame_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_f_single) begin
            w_cand_nxt  = w_m_code;
            w_dcnt_nxt  = DW'(1);
            w_state_nxt = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (w_f_single && (w_m_code == r_cand)) begin
            if (r_dcnt == DF_LAST) begin
              w_state_nxt = S_PRESSED;
              w_rcnt_nxt  = '0;
            end else begin
              w_dcnt_nxt = r_dcnt + 1'b1;
            end
          end else if (w_f_single) begin
            w_cand_nxt = w_m_code;
            w_dcnt_nxt = DW'(1);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_PRESSED: begin
          // Any key activity, including a roll-over, restarts the release count.
          if (w_f_none) begin
            if (r_rcnt == DF_LAST) begin
              w_state_nxt = S_IDLE;
              w_rcnt_nxt  = '0;
            end else begin
              w_rcnt_nxt = r_rcnt + 1'b1;
            end
          end else begin
            w_rcnt_nxt = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_accept  = (r_state == S_DEBOUNCE) && (w_state_nxt == S_PRESSED);
    w_release = (r_state == S_PRESSED) && (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key_code <= r_cand;
        r_key_down <= 1'b1;
      end else if (w_release) begin
        r_key_down <= 1'b0;
      end
    end
  end

  assign row       = r_row;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a 4-cycle row dwell and 3-frame debounce (frame = 16 cycles).
// A keypad model pulls columns low for pressed keys on the currently driven row.
module tb_keypad_scan;

  logic        sclk = 1'b0;
  logic        s_rst = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;

  logic [15:0] keys = '0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_pulse = 0;
  int          last_cyc = -1;
  logic [3:0]  last_code = 4'd0;

  keypad_scan #(.SCAN_CNT(4), .DEBOUNCE_FRAMES(3)) dut (
    .sclk      (sclk),
    .s_rst     (s_rst),
    .col_in    (col_in),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 sclk = ~sclk;

  always_comb begin
    int ridx;
    col_in = 4'hF;
    ridx = 0;
    case (row)
      4'b1101: ridx = 1;
      4'b1011: ridx = 2;
      4'b0111: ridx = 3;
      default: ridx = 0;
    endcase
    for (int c = 0; c < 4; c++) begin
      if (keys[ridx*4 + c]) col_in[c] = 1'b0;
    end
  end

  always @(posedge sclk) begin
    if (s_rst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge sclk) begin
    if (key_valid === 1'b1) begin
      n_pulse   = n_pulse + 1;
      last_cyc  = cyc;
      last_code = key_code;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge sclk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge sclk);
    s_rst = 1'b1;
    keys  = '0;
    repeat (3) @(negedge sclk);
    #1;
    chk("rst_row", row, 4'b1110);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_down", key_down, 1'b0);
    chk("rst_code", key_code, 4'd0);
    n_pulse  = 0;
    last_cyc = -1;
    s_rst    = 1'b0;
  endtask

  initial begin
    // Clean press of key 6 (row 1, col 2), plus row rotation after reset
    do_reset();
    keys = 16'h0040;
    wait_cyc(0);   chk("rot_c0", row, 4'b1110);
    wait_cyc(3);   chk("rot_c3", row, 4'b1110);
    wait_cyc(4);   chk("rot_c4", row, 4'b1101);
    wait_cyc(8);   chk("rot_c8", row, 4'b1011);
    wait_cyc(12);  chk("rot_c12", row, 4'b0111);
    wait_cyc(16);  chk("rot_c16", row, 4'b1110);
    wait_cyc(47);  chk("k6_early_pulses", n_pulse, 0);
                   chk("k6_early_down", key_down, 1'b0);
    wait_cyc(48);  chk("k6_valid", key_valid, 1'b1);
                   chk("k6_code", key_code, 4'd6);
                   chk("k6_down", key_down, 1'b1);
    wait_cyc(49);  chk("k6_valid_1cyc", key_valid, 1'b0);
    wait_cyc(64);  keys = '0;
    wait_cyc(111); chk("k6_down_held", key_down, 1'b1);
    wait_cyc(112); chk("k6_released", key_down, 1'b0);
                   chk("k6_code_kept", key_code, 4'd6);
                   chk("k6_pulses", n_pulse, 1);

    // Bounce on key 9: 2 frames held, 1 released, then 3 held
    do_reset();
    keys = 16'h0200;
    wait_cyc(32);  keys = '0;
    wait_cyc(48);  keys = 16'h0200;
                   chk("k9_bounce_pulses", n_pulse, 0);
    wait_cyc(95);  chk("k9_early_pulses", n_pulse, 0);
    wait_cyc(100); chk("k9_pulses", n_pulse, 1);
                   chk("k9_cyc", last_cyc, 96);
                   chk("k9_code", last_code, 4'd9);

    // Multi-key: keys 0 and 15 together, then 15 released
    do_reset();
    keys = 16'h8001;
    wait_cyc(160); chk("multi_pulses", n_pulse, 0);
                   chk("multi_down", key_down, 1'b0);
                   keys = 16'h0001;
    wait_cyc(215); chk("k0_pulses", n_pulse, 1);
                   chk("k0_cyc", last_cyc, 208);
                   chk("k0_code", last_code, 4'd0);
                   chk("k0_down", key_down, 1'b1);

    // Roll-over from key 3 to key 12 without an empty frame
    do_reset();
    keys = 16'h0008;
    wait_cyc(64);  chk("k3_pulses", n_pulse, 1);
                   chk("k3_code", key_code, 4'd3);
                   keys = 16'h1000;
    wait_cyc(127); chk("roll_pulses", n_pulse, 1);
                   chk("roll_down", key_down, 1'b1);
                   chk("roll_code", key_code, 4'd3);
    wait_cyc(128); keys = '0;
    wait_cyc(175); chk("roll_down_held", key_down, 1'b1);
    wait_cyc(176); chk("roll_released", key_down, 1'b0);
                   keys = 16'h1000;
    wait_cyc(230); chk("k12_pulses", n_pulse, 2);
                   chk("k12_cyc", last_cyc, 224);
                   chk("k12_code", last_code, 4'd12);

    // Reset in the middle of debouncing key 5
    do_reset();
    keys = 16'h0020;
    wait_cyc(32);  s_rst = 1'b1;
    @(negedge sclk);
    #1;
    chk("midrst_valid", key_valid, 1'b0);
    chk("midrst_row", row, 4'b1110);
    chk("midrst_down", key_down, 1'b0);
    s_rst = 1'b0;
    wait_cyc(47);  chk("k5_early_pulses", n_pulse, 0);
    wait_cyc(48);  chk("k5_valid", key_valid, 1'b1);
                   chk("k5_code", key_code, 4'd5);
    wait_cyc(52);  chk("k5_pulses", n_pulse, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
